sprite_blit_ctrl: RTL and testbench

Sequencer that copies one sprite image, e.g. the 60x84 cabbage sprite, from a sprite RAM into the frame buffer at a commanded screen position. It owns the sprite RAM read port and the frame-buffer write port. It walks the sprite row-major at one pixel per clock and absorbs the RAM's one-cycle registered read latency. It skips transparent pixels, clips at the right and bottom screen edges, and reports completion. It sits between the game-logic draw scheduler and the sprite RAM / frame buffer.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_addr_gen.sv | 60 ++++++
 rtl/sprite_blit_ctrl.sv | 129 ++++++++++++
 tb/tb_sprite_blit_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite blitter.
// Screen geometry, colour key, FSM state encoding and address type.
package sprite_pkg;

   localparam int SCR_W = 640;
   localparam int SCR_H = 480;

   localparam logic [23:0] TRANSPARENT = 24'h000000;

   typedef logic [18:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Row-major col/row walker for the sprite blitter.
// Produces the sprite RAM address, the screen address and the edge-clip flag.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int SPR_W = 60,
   parameter int SPR_H = 84
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [18:0] base,
   input  logic [9:0]  org_x,
   input  logic [8:0]  org_y,
   output logic [18:0] spr_addr,
   output logic [18:0] scr_addr,
   output logic        clip,
   output logic        last
);

   localparam int COL_W = $clog2(SPR_W);
   localparam int ROW_W = $clog2(SPR_H);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [10:0]      sx;
   logic [9:0]       sy;
   logic             col_end;
   logic             row_end;

   assign col_end = (col == COL_W'(SPR_W - 1));
   assign row_end = (row == ROW_W'(SPR_H - 1));

   always_ff @(posedge Clk) begin
      if (Reset || clear) begin
         col <= '0;
         row <= '0;
      end else if (enable) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // sx/sy are one bit wider than the screen coordinates so an overhang past the edge is visible to the clip test.
   always_comb begin
      sx       = {1'b0, org_x} + 11'(col);
      sy       = {1'b0, org_y} + 10'(row);
      spr_addr = base + addr_t'(row) * addr_t'(SPR_W) + addr_t'(col);
      scr_addr = addr_t'(sy) * addr_t'(SCR_W) + addr_t'(sx);
      clip     = (sx >= 11'(SCR_W)) || (sy >= 10'(SCR_H));
      last     = col_end && row_end;
   end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Sprite-to-frame-buffer copy sequencer: one pixel per clock, colour-keyed,
// clipped at the right/bottom screen edges, stallable by hold.
//
// state | meaning
// IDLE  | waiting for a draw command, cmd_ready high
// RUN   | issuing one sprite RAM read per clock
// DRAIN | writing the last in-flight pixel
// DONE  | one-cycle completion pulse
module sprite_blit_ctrl
   import sprite_pkg::*;
#(
   parameter int SPR_W = 60,
   parameter int SPR_H = 84
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [18:0] cmd_base,
   input  logic        hold,
   output logic [18:0] spr_read_address,
   input  logic [23:0] spr_data,
   output logic        fb_we,
   output logic [18:0] fb_addr,
   output logic [23:0] fb_data,
   output logic        busy,
   output logic        done
);

   state_t state;
   state_t state_nxt;

   logic       accept;
   logic       advance;
   logic [9:0] x_q;
   logic [8:0] y_q;
   addr_t      base_q;

   addr_t gen_spr_addr;
   addr_t gen_scr_addr;
   logic  gen_clip;
   logic  gen_last;

   logic  p1_valid;
   logic  p1_clip;
   addr_t p1_spr_addr;
   addr_t p1_scr_addr;

   assign accept  = (state == IDLE) && cmd_valid;
   assign advance = (state == RUN) && !hold;

   sprite_addr_gen #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_addr_gen (
      .Clk      (Clk),
      .Reset    (Reset),
      .clear    (accept),
      .enable   (advance),
      .base     (base_q),
      .org_x    (x_q),
      .org_y    (y_q),
      .spr_addr (gen_spr_addr),
      .scr_addr (gen_scr_addr),
      .clip     (gen_clip),
      .last     (gen_last)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid)           state_nxt = RUN;
         RUN:     if (!hold && gen_last)   state_nxt = DRAIN;
         DRAIN:   if (!hold)               state_nxt = DONE;
         DONE:                             state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q    <= '0;
         y_q    <= '0;
         base_q <= '0;
      end else if (accept) begin
         x_q    <= cmd_x;
         y_q    <= cmd_y;
         base_q <= cmd_base;
      end
   end

   // p1 tracks the pixel whose RAM data arrives next cycle; it is frozen by hold so no pixel is lost.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         p1_valid    <= 1'b0;
         p1_clip     <= 1'b0;
         p1_spr_addr <= '0;
         p1_scr_addr <= '0;
      end else if (!hold) begin
         p1_valid    <= advance;
         p1_clip     <= gen_clip;
         p1_spr_addr <= gen_spr_addr;
         p1_scr_addr <= gen_scr_addr;
      end
   end

   // During a stall the RAM re-reads the in-flight pixel so spr_data stays valid at release.
   always_comb begin
      spr_read_address = '0;
      if (hold && p1_valid)    spr_read_address = p1_spr_addr;
      else if (state == RUN)   spr_read_address = gen_spr_addr;
   end

   assign fb_we     = p1_valid && !p1_clip && !hold && (spr_data != TRANSPARENT);
   assign fb_addr   = p1_scr_addr;
   assign fb_data   = spr_data;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Directed bench for sprite_blit_ctrl with a registered-read sprite RAM model
// and an independent row/col model of the expected frame-buffer writes.
module tb_sprite_blit_ctrl;

   logic        Clk;
   logic        Reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [18:0] cmd_base;
   logic        hold;
   logic [18:0] spr_read_address;
   logic [23:0] spr_data;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [23:0] fb_data;
   logic        busy;
   logic        done;

   sprite_blit_ctrl dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_x            (cmd_x),
      .cmd_y            (cmd_y),
      .cmd_base         (cmd_base),
      .hold             (hold),
      .spr_read_address (spr_read_address),
      .spr_data         (spr_data),
      .fb_we            (fb_we),
      .fb_addr          (fb_addr),
      .fb_data          (fb_data),
      .busy             (busy),
      .done             (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] ram [0:8191];
   logic [18:0] wa [$];
   logic [23:0] wd [$];
   logic        capture;
   int          n_hi;

   int dc;
   int hits;
   int early_ready;
   int busy_bad;
   int got_done;
   logic [18:0] last_a;
   logic [23:0] last_d;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) spr_data <= ram[spr_read_address[12:0]];

   always @(negedge Clk) begin
      if (capture && fb_we) begin
         wa.push_back(fb_addr);
         wd.push_back(fb_data);
         if (fb_addr >= 19'd307200) n_hi++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected writes: walk the sprite, keep on-screen non-key pixels, compare in order.
   function automatic int seq_errors(input int x, input int y, input int b);
      int k = 0;
      int errs = 0;
      for (int r = 0; r < 84; r++) begin
         for (int c = 0; c < 60; c++) begin
            int sx = x + c;
            int sy = y + r;
            logic [23:0] d = ram[(b + r * 60 + c) % 8192];
            if (sx < 640 && sy < 480 && d != 24'h0) begin
               if (k >= wa.size()) errs++;
               else if (wa[k] !== 19'(sy * 640 + sx) || wd[k] !== d) errs++;
               k++;
            end
         end
      end
      if (k != wa.size()) errs++;
      return errs;
   endfunction

   task automatic run_draw(input logic [9:0] x, input logic [8:0] y, input logic [18:0] b,
                           input bit use_hold, output int done_cyc);
      wa.delete();
      wd.delete();
      n_hi = 0;
      @(posedge Clk); #1;
      cmd_x = x; cmd_y = y; cmd_base = b; cmd_valid = 1'b1;
      @(posedge Clk); #1;
      cmd_valid = 1'b0;
      capture = 1'b1;
      done_cyc = -1;
      for (int n = 1; n <= 6000 && done_cyc < 0; n++) begin
         hold = use_hold && ((n >= 100 && n < 110) || n == 3000);
         @(negedge Clk);
         if (done) done_cyc = n;
         @(posedge Clk); #1;
      end
      hold = 1'b0;
      capture = 1'b0;
   endtask

   function automatic void load_ramp(input bit key7);
      for (int i = 0; i < 8192; i++)
         ram[i] = (key7 && (i % 7 == 0)) ? 24'h0 : 24'(i + 1);
   endfunction

   initial begin
      Reset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_base = '0;
      hold = 1'b0; capture = 1'b0; spr_data = '0; n_hi = 0;
      load_ramp(1'b0);
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fb_we", 32'(fb_we), 0);
      chk("rst_spr_addr", 32'(spr_read_address), 0);

      // full sprite at origin
      run_draw(10'd0, 9'd0, 19'd0, 1'b0, dc);
      last_a = (wa.size() > 0) ? wa[wa.size()-1] : '1;
      last_d = (wd.size() > 0) ? wd[wd.size()-1] : '1;
      chk("ramp_writes", 32'(wa.size()), 5040);
      chk("ramp_last_addr", 32'(last_a), 53179);
      chk("ramp_last_data", 32'(last_d), 5040);
      chk("ramp_done_cyc", 32'(dc), 5042);
      chk("ramp_seq", 32'(seq_errors(0, 0, 0)), 0);
      @(negedge Clk);
      chk("ramp_ready_after", 32'(cmd_ready), 1);
      chk("ramp_busy_after", 32'(busy), 0);

      // colour key on every 7th word
      load_ramp(1'b1);
      run_draw(10'd0, 9'd0, 19'd0, 1'b0, dc);
      hits = 0;
      foreach (wa[i]) if (((int'(wa[i]) / 640) * 60 + int'(wa[i]) % 640) % 7 == 0) hits++;
      chk("key_writes", 32'(wa.size()), 4320);
      chk("key_hits", 32'(hits), 0);
      chk("key_seq", 32'(seq_errors(0, 0, 0)), 0);

      // clipped at bottom-right corner
      load_ramp(1'b0);
      run_draw(10'd600, 9'd420, 19'd0, 1'b0, dc);
      chk("clip_writes", 32'(wa.size()), 2400);
      chk("clip_hi_addr", 32'(n_hi), 0);
      chk("clip_done_cyc", 32'(dc), 5042);
      chk("clip_seq", 32'(seq_errors(600, 420, 0)), 0);

      // hold stalls, with a non-zero base
      run_draw(10'd0, 9'd0, 19'd1000, 1'b1, dc);
      chk("hold_writes", 32'(wa.size()), 5040);
      chk("hold_done_cyc", 32'(dc), 5053);
      chk("hold_seq", 32'(seq_errors(0, 0, 1000)), 0);

      // reset mid-draw, then a fresh draw
      @(posedge Clk); #1;
      cmd_x = '0; cmd_y = '0; cmd_base = '0; cmd_valid = 1'b1;
      @(posedge Clk); #1;
      cmd_valid = 1'b0;
      repeat (1999) @(posedge Clk);
      @(negedge Clk);
      chk("mid_fb_we_before", 32'(fb_we), 1);
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("mid_fb_we_after", 32'(fb_we), 0);
      chk("mid_ready_after", 32'(cmd_ready), 1);
      chk("mid_busy_after", 32'(busy), 0);
      run_draw(10'd100, 9'd50, 19'd0, 1'b0, dc);
      chk("redraw_writes", 32'(wa.size()), 5040);
      chk("redraw_done_cyc", 32'(dc), 5042);
      chk("redraw_seq", 32'(seq_errors(100, 50, 0)), 0);

      // cmd_valid held high across two draws
      @(posedge Clk); #1;
      cmd_x = 10'd5; cmd_y = 9'd5; cmd_base = '0; cmd_valid = 1'b1;
      @(posedge Clk); #1;
      early_ready = 0; busy_bad = 0; got_done = 0;
      for (int n = 1; n <= 5042; n++) begin
         @(negedge Clk);
         if (cmd_ready) early_ready++;
         if (busy !== (n <= 5041)) busy_bad++;
         if (n == 5042) got_done = int'(done);
         @(posedge Clk); #1;
      end
      chk("b2b_early_ready", 32'(early_ready), 0);
      chk("b2b_busy", 32'(busy_bad), 0);
      chk("b2b_done", 32'(got_done), 1);
      @(negedge Clk);
      chk("b2b_ready_5043", 32'(cmd_ready), 1);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("b2b_busy_5044", 32'(busy), 1);
      cmd_valid = 1'b0;
      got_done = 0;
      for (int n = 0; n < 6000 && got_done == 0; n++) begin
         @(negedge Clk);
         if (done) got_done = 1;
      end
      chk("b2b_second_done", 32'(got_done), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
